// File: rtl/ctrl_pipe_if.sv
// Decoded control bus between ID and the ctrl_pipe stage registers.
// The master side drives the step controls and the bundle, the slave side returns the per-stage fields.
interface ctrl_pipe_if #(
    parameter int NB_SGN = 20,
    parameter int NB_CNT = 32
);
    logic              i_enable;
    logic              i_valid;
    logic              i_stall;
    logic              i_flush;
    logic [NB_SGN-1:0] i_signals;

    logic              o_ex_reg_dst;
    logic              o_ex_alu_src;
    logic              o_ex_jal_sel;
    logic [3:0]        o_ex_alu_op;
    logic              o_ex_mem_read;
    logic              o_ex_reg_write;

    logic              o_mem_mem_read;
    logic              o_mem_mem_write;
    logic              o_mem_mem_to_reg;
    logic              o_mem_reg_write;
    logic              o_mem_is_jal;
    logic [2:0]        o_mem_bhw;

    logic              o_wb_mem_to_reg;
    logic              o_wb_reg_write;
    logic              o_wb_is_jal;
    logic              o_wb_halt;

    logic              o_halted;
    logic [NB_CNT-1:0] o_retired;
    logic [1:0]        o_dbg_state;

    modport master (
        output i_enable, i_valid, i_stall, i_flush, i_signals,
        input  o_ex_reg_dst, o_ex_alu_src, o_ex_jal_sel, o_ex_alu_op, o_ex_mem_read, o_ex_reg_write,
        input  o_mem_mem_read, o_mem_mem_write, o_mem_mem_to_reg, o_mem_reg_write, o_mem_is_jal, o_mem_bhw,
        input  o_wb_mem_to_reg, o_wb_reg_write, o_wb_is_jal, o_wb_halt,
        input  o_halted, o_retired, o_dbg_state
    );

    modport slave (
        input  i_enable, i_valid, i_stall, i_flush, i_signals,
        output o_ex_reg_dst, o_ex_alu_src, o_ex_jal_sel, o_ex_alu_op, o_ex_mem_read, o_ex_reg_write,
        output o_mem_mem_read, o_mem_mem_write, o_mem_mem_to_reg, o_mem_reg_write, o_mem_is_jal, o_mem_bhw,
        output o_wb_mem_to_reg, o_wb_reg_write, o_wb_is_jal, o_wb_halt,
        output o_halted, o_retired, o_dbg_state
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline ID/EX -> EX/MEM -> MEM/WB with stall/flush bubbles and a halt drain FSM.
// Define CTRL_PIPE_DEBUG_EN to build the retired-instruction counter and expose the FSM state.
module ctrl_pipe #(
    parameter int NB_SGN = 20,
    parameter int NB_CNT = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    ctrl_pipe_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Field order matches bits 15:0 of the incoming bundle.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       jal_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic [2:0] bhw;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       is_jal;
        logic       halt;
    } ex_fields_t;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic [2:0] bhw;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       is_jal;
        logic       halt;
    } mem_fields_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_wr;
        logic is_jal;
        logic halt;
    } wb_fields_t;

    state_t      r_state;
    state_t      w_state_next;
    ex_fields_t  r_ex;
    ex_fields_t  w_ex_next;
    ex_fields_t  w_id_fields;
    mem_fields_t r_mem;
    mem_fields_t w_mem_next;
    wb_fields_t  r_wb;
    wb_fields_t  w_wb_next;
    logic        r_ex_valid;
    logic        r_mem_valid;
    logic        r_wb_valid;
    logic        w_ex_valid_next;
    logic        w_mem_valid_next;
    logic        w_wb_valid_next;
    logic        w_ex_load;
    logic        w_halted;

    // Jump/branch bits are resolved in ID and never travel down the pipe.
    logic [3:0]  w_unused_id;
    assign w_unused_id = bus.i_signals[NB_SGN-1:NB_SGN-4];

    assign w_id_fields = ex_fields_t'(bus.i_signals[NB_SGN-5:0]);
    assign w_halted    = (r_state == ST_HALTED);
    assign w_ex_load   = bus.i_valid & ~bus.i_stall & ~bus.i_flush & (r_state == ST_RUN);

    // Next contents of the three stage registers.
    always_comb begin
        w_ex_next        = '0;
        w_ex_valid_next  = 1'b0;
        w_mem_next       = '0;
        w_mem_valid_next = 1'b0;
        w_wb_next        = '0;
        w_wb_valid_next  = 1'b0;
        if (w_ex_load) begin
            w_ex_next       = w_id_fields;
            w_ex_valid_next = 1'b1;
        end else begin
            w_ex_next       = '0;
            w_ex_valid_next = 1'b0;
        end
        if (w_halted) begin
            w_mem_next       = '0;
            w_mem_valid_next = 1'b0;
            w_wb_next        = '0;
            w_wb_valid_next  = 1'b0;
        end else begin
            w_mem_next.mem_rd     = r_ex.mem_rd;
            w_mem_next.mem_wr     = r_ex.mem_wr;
            w_mem_next.bhw        = r_ex.bhw;
            w_mem_next.mem_to_reg = r_ex.mem_to_reg;
            w_mem_next.reg_wr     = r_ex.reg_wr;
            w_mem_next.is_jal     = r_ex.is_jal;
            w_mem_next.halt       = r_ex.halt;
            w_mem_valid_next      = r_ex_valid;
            w_wb_next.mem_to_reg  = r_mem.mem_to_reg;
            w_wb_next.reg_wr      = r_mem.reg_wr;
            w_wb_next.is_jal      = r_mem.is_jal;
            w_wb_next.halt        = r_mem.halt;
            w_wb_valid_next       = r_mem_valid;
        end
    end

    // Halt sequencing: RUN until a halt enters EX, DRAIN until it reaches WB, then HALTED.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_ex_load && w_id_fields.halt) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (r_wb_valid && r_wb.halt) begin
                    w_state_next = ST_HALTED;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Stage registers and FSM state; reset wins over enable, enable low holds everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_ex        <= '0;
            r_ex_valid  <= 1'b0;
            r_mem       <= '0;
            r_mem_valid <= 1'b0;
            r_wb        <= '0;
            r_wb_valid  <= 1'b0;
        end else if (bus.i_enable) begin
            r_state     <= w_state_next;
            r_ex        <= w_ex_next;
            r_ex_valid  <= w_ex_valid_next;
            r_mem       <= w_mem_next;
            r_mem_valid <= w_mem_valid_next;
            r_wb        <= w_wb_next;
            r_wb_valid  <= w_wb_valid_next;
        end
    end

`ifdef CTRL_PIPE_DEBUG_EN
    logic [NB_CNT-1:0] r_retired;

    // Count instructions leaving WB; the halt marker itself is not an instruction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_retired <= {NB_CNT{1'b0}};
        end else if (bus.i_enable && r_wb_valid && !r_wb.halt) begin
            r_retired <= r_retired + {{(NB_CNT-1){1'b0}}, 1'b1};
        end
    end

    assign bus.o_retired   = r_retired;
    assign bus.o_dbg_state = r_state;
`else
    assign bus.o_retired   = {NB_CNT{1'b0}};
    assign bus.o_dbg_state = 2'd0;
`endif

    assign bus.o_ex_reg_dst     = r_ex.reg_dst;
    assign bus.o_ex_alu_src     = r_ex.alu_src;
    assign bus.o_ex_jal_sel     = r_ex.jal_sel;
    assign bus.o_ex_alu_op      = r_ex.alu_op;
    assign bus.o_ex_mem_read    = r_ex.mem_rd;
    assign bus.o_ex_reg_write   = r_ex.reg_wr;

    assign bus.o_mem_mem_read   = r_mem.mem_rd;
    assign bus.o_mem_mem_write  = r_mem.mem_wr;
    assign bus.o_mem_mem_to_reg = r_mem.mem_to_reg;
    assign bus.o_mem_reg_write  = r_mem.reg_wr;
    assign bus.o_mem_is_jal     = r_mem.is_jal;
    assign bus.o_mem_bhw        = r_mem.bhw;

    assign bus.o_wb_mem_to_reg  = r_wb.mem_to_reg;
    assign bus.o_wb_reg_write   = r_wb.reg_wr;
    assign bus.o_wb_is_jal      = r_wb.is_jal;
    assign bus.o_wb_halt        = r_wb.halt;

    assign bus.o_halted         = w_halted;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: a record-level pipeline model queues the expected output set
// after every clock edge and a negedge monitor compares it with the DUT.
module tb_ctrl_pipe;
    logic i_clk;
    logic i_rst;

    ctrl_pipe_if #(.NB_SGN(20), .NB_CNT(32)) bus ();

    ctrl_pipe #(.NB_SGN(20), .NB_CNT(32)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cycle  = 0;

    logic [55:0] q_exp[$];

    // Reference model: each stage is a record {valid, bundle}; mode 0 run, 1 draining, 2 halted.
    logic [20:0] m_ex;
    logic [20:0] m_mem;
    logic [20:0] m_wb;
    int          m_mode;
    logic [31:0] m_ret;

    task automatic model_edge(input bit rst, input bit en, input bit vld, input bit stl,
                              input bit fls, input logic [19:0] sig);
        int nm;
        bit acc;
        if (rst) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_mode = 0; m_ret = 32'd0;
        end else if (en) begin
            nm = m_mode;
            if (m_wb[20] && !m_wb[0]) m_ret = m_ret + 32'd1;
            if (m_mode == 1 && m_wb[20] && m_wb[0]) nm = 2;
            acc = vld && !stl && !fls && (m_mode == 0);
            if (acc && sig[0]) nm = 1;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = acc ? {1'b1, sig} : 21'd0;
            m_mode = nm;
        end
    endtask

    function automatic logic [55:0] model_vec();
        logic [19:0] e, m, w;
        logic [31:0] ret;
        logic [1:0]  dbg;
        e = m_ex[19:0];
        m = m_mem[19:0];
        w = m_wb[19:0];
`ifdef CTRL_PIPE_DEBUG_EN
        ret = m_ret;
        dbg = 2'(m_mode);
`else
        ret = 32'd0;
        dbg = 2'd0;
`endif
        return {e[15], e[14], e[13:10], e[9], e[8], e[2],
                m[8], m[7], m[3], m[2], m[1], m[6:4],
                w[3], w[2], w[1], w[0],
                (m_mode == 2), ret, dbg};
    endfunction

    function automatic logic [55:0] dut_vec();
        return {bus.o_ex_reg_dst, bus.o_ex_alu_src, bus.o_ex_alu_op, bus.o_ex_jal_sel,
                bus.o_ex_mem_read, bus.o_ex_reg_write,
                bus.o_mem_mem_read, bus.o_mem_mem_write, bus.o_mem_mem_to_reg,
                bus.o_mem_reg_write, bus.o_mem_is_jal, bus.o_mem_bhw,
                bus.o_wb_mem_to_reg, bus.o_wb_reg_write, bus.o_wb_is_jal, bus.o_wb_halt,
                bus.o_halted, bus.o_retired, bus.o_dbg_state};
    endfunction

    task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, n_cycle, act, exp);
        end
    endtask

    // Monitor: one expected snapshot per clock edge, compared mid-cycle.
    always @(negedge i_clk) begin
        if (q_exp.size() > 0) begin
            check("outputs", dut_vec(), q_exp.pop_front());
        end
    end

    // Drive one cycle of inputs (called just after a negedge), then record the expectation.
    task automatic step(input bit rst, input bit en, input bit vld, input bit stl,
                        input bit fls, input logic [19:0] sig);
        i_rst         = rst;
        bus.i_enable  = en;
        bus.i_valid   = vld;
        bus.i_stall   = stl;
        bus.i_flush   = fls;
        bus.i_signals = sig;
        @(posedge i_clk);
        n_cycle++;
        model_edge(rst, en, vld, stl, fls, sig);
        q_exp.push_back(model_vec());
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000);
    endtask

    localparam logic [19:0] ADDU = 20'h00804;
    localparam logic [19:0] LW   = 20'h0C13C;
    localparam logic [19:0] BEQ  = 20'h03C00;
    localparam logic [19:0] HALT = 20'h00001;

    initial begin
        logic [19:0] s;
        i_rst = 1'b1; bus.i_enable = 1'b0; bus.i_valid = 1'b0;
        bus.i_stall = 1'b0; bus.i_flush = 1'b0; bus.i_signals = 20'h00000;
        m_ex = '0; m_mem = '0; m_wb = '0; m_mode = 0; m_ret = 32'd0;
        @(negedge i_clk);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ADDU);
        check("reset_zero", dut_vec(), 56'd0);

        // Single ADDU through all stages.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ADDU);
        check("addu_ex_alu_op", {52'd0, bus.o_ex_alu_op}, {52'd0, 4'b0010});
        idle(4);

        // LW followed by a one-cycle load-use stall, then the held bundle.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, LW);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ADDU);
        check("lw_mem_bhw", {52'd0, bus.o_mem_mem_read, bus.o_mem_bhw}, {52'd0, 1'b1, 3'b011});
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ADDU);
        idle(4);

        // Flushed BEQ and a flushed halt leave no trace.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, BEQ);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, HALT);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, HALT);
        idle(4);

        // Two ADDUs then HALT; later bundles are ignored.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ADDU);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ADDU);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, HALT);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ADDU);
        check("halted_flag", {55'd0, bus.o_halted}, {55'd0, 1'b1});

        // Enable low for five cycles mid-stream.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ADDU);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, LW);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'hFFFFF);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BEQ);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ADDU);
        idle(4);

        // Reset during DRAIN, then normal flow.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, HALT);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ADDU);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ADDU);
        idle(4);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            s = 20'($urandom);
            if ($urandom_range(0, 15) != 0) s[0] = 1'b0;
            if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, s);
            end else begin
                step(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), s);
            end
        end

        for (int k = 0; k < 10 && q_exp.size() > 0; k++) @(negedge i_clk);
        check("queue_drained", 56'(q_exp.size()), 56'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the 20-bit decoded control bus: accepts the bundle produced in ID and carries each field through the ID/EX, EX/MEM and MEM/WB stage registers.
- Exposes each field at the stage that uses it.
- Applies hazard-unit stall/flush bubbles.
- Runs the halt drain sequence and counts retired instructions for the debug unit.

Parameters:
- NB_SGN, 20, width of the incoming control bundle; fixed field layout below.
- NB_CNT, 32, width of the retired-instruction counter.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline step enable from debug unit; low = all state holds
- i_valid  in  1  IF/ID holds a real instruction
- i_stall  in  1  load-use stall: bubble into ID/EX
- i_flush  in  1  taken branch/jump: bubble into ID/EX
- i_signals  in  NB_SGN  bundle. Bit layout: 19 Jump, 18 JSel, 17 Branch, 16 IsBeq, 15 RegDst, 14 AluSrc, 13:10 AluOp, 9 JalSel, 8 MemRd, 7 MemWr, 6:4 BHW, 3 MemToReg, 2 RegWr, 1 IsJal, 0 halt
- o_ex_reg_dst, o_ex_alu_src, o_ex_jal_sel  out  1 each
- o_ex_alu_op  out  4
- o_ex_mem_read, o_ex_reg_write  out  1 each  (to hazard/forwarding units)
- o_mem_mem_read, o_mem_mem_write, o_mem_mem_to_reg, o_mem_reg_write, o_mem_is_jal  out  1 each
- o_mem_bhw  out  3
- o_wb_mem_to_reg, o_wb_reg_write, o_wb_is_jal, o_wb_halt  out  1 each
- o_halted  out  1  processor halted
- o_retired  out  NB_CNT  retired-instruction count (see Optional Feature)
- o_dbg_state  out  2  FSM state (see Optional Feature)

Behaviour:
- Reset (i_rst high at an edge): all stage registers cleared to 0 including valid bits; FSM = RUN; o_retired = 0; every output = 0. Reset overrides i_enable.
- Bits 19:16 (Jump, JSel, Branch, IsBeq) are consumed in ID and are not stored.
- Each stage register holds its fields plus a valid bit.
- i_enable low: no register, counter or FSM changes.
- ID/EX load value, when i_enable is high:
  - bubble (all fields 0, valid 0) if i_stall | i_flush | ~i_valid | FSM != RUN;
  - otherwise i_signals with valid = 1.
- EX/MEM and MEM/WB always advance from the previous stage when i_enable is high, including during a stall.
- Latency: bundle sampled at edge N → o_ex_* after N, o_mem_* after N+1, o_wb_* after N+2 (enable held high).
- Outputs are driven directly from the stage registers; no combinational path from inputs.
- FSM:
  - RUN → DRAIN when a valid bundle with halt = 1 is loaded into ID/EX.
  - DRAIN → HALTED on the enabled edge where MEM/WB holds halt = 1 (that value was visible as o_wb_halt in the preceding cycle).
  - HALTED is absorbing until reset.
  - o_halted = (state == HALTED).
- Halt arriving together with i_flush or i_stall is dropped; FSM stays in RUN.
- Instructions in EX/MEM ahead of the halt complete normally during DRAIN.
- In HALTED, all stage registers hold bubbles.
- Retire counter: +1 on each enabled edge where MEM/WB valid = 1 and halt = 0. The halt itself is not counted. Wraps modulo 2^NB_CNT.

Optional Feature:
- Macro CTRL_PIPE_DEBUG_EN.
- Defined: retire counter implemented and driven onto o_retired; o_dbg_state = 0 RUN, 1 DRAIN, 2 HALTED.
- Undefined: counter not synthesized; o_retired and o_dbg_state tied to 0.
- Pipeline and halt behaviour are identical either way.

Test Plan:
- Reset then ADDU bundle 0x00804 (valid, enable): o_ex_alu_op = 4'b0010 and o_ex_reg_write = 1 after 1 edge; o_mem_reg_write = 1 after 2; o_wb_reg_write = 1 after 3; o_retired = 1 after 4.
- LW bundle 0x0C13C followed by i_stall = 1 for one cycle: o_mem_mem_read = 1 and o_mem_bhw = 3'b011 while ID/EX shows bubble (o_ex_alu_src = 0); next bundle is delayed exactly one cycle.
- BEQ bundle 0x3C00 with i_flush = 1: ID/EX bubble; no MEM/WB activity; o_retired unchanged.
- HALT 0x00001 after two ADDUs: o_wb_halt = 1 three edges after halt sampled; o_halted = 1 one edge later; o_retired = 2; later inputs ignored.
- i_enable low for 5 cycles mid-stream: all outputs frozen; resume with the same sequence and no loss.
- i_rst asserted while in DRAIN: next cycle all outputs 0, FSM RUN; a new ADDU flows normally.
